// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- one-entry valid/ready pipeline register with optional skid.
//
// Build option: define PIPE_STAGE_SKID_EN to add one skid entry behind the
// output register. In that build in_ready_o is a registered "skid empty" flag,
// so the upstream ready path does not depend combinationally on out_ready_i.
// Without it, the stage holds a single entry and in_ready_o is combinational.
//
// Control bits are zeroed whenever the output holds no valid entry, so a
// bubble never carries stale control downstream. Payload data is left as-is
// on a bubble, except that flush and reset zero it.

module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  // Output register
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = out_valid_q && out_ready_i;

  assign out_valid_o = out_valid_q;
  assign out_ctrl_o  = out_ctrl_q;
  assign out_data_o  = out_data_q;

`ifdef PIPE_STAGE_SKID_EN

  // Skid entry plus registered ready. Invariant: the skid entry is only ever
  // valid while the output entry is valid, so it always holds the younger one.
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_ready_q,   in_ready_d;

  assign in_ready_o = in_ready_q;
  assign count_o    = {out_valid_q & skid_valid_q, out_valid_q ^ skid_valid_q};

  // Next-state for output and skid entries; flush wins over any transfer
  always_comb begin
    out_valid_d  = out_valid_q;
    out_ctrl_d   = out_ctrl_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      out_ctrl_d   = '0;
      out_data_d   = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      skid_data_d  = '0;
    end else if (out_xfer || !out_valid_q) begin
      // Output slot frees up on this edge: oldest remaining entry moves in.
      if (skid_valid_q) begin
        // in_ready_o is low here, so no new entry can arrive this edge.
        out_valid_d  = 1'b1;
        out_ctrl_d   = skid_ctrl_q;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_ctrl_d  = in_ctrl_i;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
        out_ctrl_d  = '0;
      end
    end else if (in_xfer) begin
      // Output is stalled: park the accepted entry in the skid slot.
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl_i;
      skid_data_d  = in_data_i;
    end
    in_ready_d = !skid_valid_d;
  end

  // Skid entry and ready flop
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

`else

  // Single-entry stage: can take a new entry when empty or draining this edge.
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign count_o    = {1'b0, out_valid_q};

  // Next-state for the output entry; flush wins over any transfer
  always_comb begin
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
      out_data_d  = '0;
    end else if (in_xfer) begin
      out_valid_d = 1'b1;
      out_ctrl_d  = in_ctrl_i;
      out_data_d  = in_data_i;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end
  end

`endif

  // Output register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps plus a short random phase, with a
// scoreboard queue holding the entries the stage should currently own.
// Inputs change 1ns after a rising edge; checks and scoreboard updates happen
// on the falling edge, when inputs for the coming edge are stable.

module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 8;
`ifdef PIPE_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [CW-1:0] in_ctrl_i;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [CW-1:0] out_ctrl_o;
  logic [DW-1:0] out_data_o;
  logic [1:0]    count_o;

  int checks   = 0;
  int failures = 0;

  entry_t        q[$];
  logic [DW-1:0] last_data = '0;
  logic          last_acc  = 1'b0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_ctrl_i  (in_ctrl_i),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_ctrl_o (out_ctrl_o),
    .out_data_o (out_data_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare outputs against held entries, then apply this edge's transfers
  always @(negedge clk) begin
    logic exp_ready;
    logic in_x, out_x;
    if (!rst_i) begin
      q.delete();
      last_data = '0;
      last_acc  = 1'b0;
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_count",     64'(count_o),     64'd0);
      chk("rst_in_ready",  64'(in_ready_o),  64'd1);
      chk("rst_out_ctrl",  64'(out_ctrl_o),  64'd0);
      chk("rst_out_data",  64'(out_data_o),  64'd0);
    end else begin
      if (DEPTH == 2) exp_ready = (q.size() < 2);
      else            exp_ready = (q.size() == 0) || out_ready_i;
      chk("in_ready",  64'(in_ready_o),  64'(exp_ready));
      chk("count",     64'(count_o),     64'(q.size()));
      chk("out_valid", 64'(out_valid_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_data", 64'(out_data_o), 64'(q[0].data));
        chk("out_ctrl", 64'(out_ctrl_o), 64'(q[0].ctrl));
      end else begin
        chk("bubble_ctrl", 64'(out_ctrl_o), 64'd0);
        chk("bubble_data", 64'(out_data_o), 64'(last_data));
      end
      if (flush_i) begin
        q.delete();
        last_data = '0;
        last_acc  = 1'b0;
      end else begin
        out_x = (q.size() != 0) && out_ready_i;
        in_x  = in_valid_i && exp_ready;
        if (out_x) begin
          last_data = q[0].data;
          void'(q.pop_front());
        end
        if (in_x) q.push_back('{ctrl: in_ctrl_i, data: in_data_i});
        last_acc = in_x;
      end
    end
  end

  // One clock of stimulus: inputs applied now, then advance to 1ns past the next edge
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
    in_valid_i  = v;
    in_ctrl_i   = c;
    in_data_i   = d;
    out_ready_i = ordy;
    flush_i     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] bp_data [3];
    int idx;
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
    in_ctrl_i = '0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;

    // Bubble: control on an invalid input must not leak to the output
    repeat (3) step(1'b0, 8'hFF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("bubble_direct_ctrl",  64'(out_ctrl_o),  64'd0);
    chk("bubble_direct_valid", 64'(out_valid_o), 64'd0);

    // Streaming 0x1..0xA with downstream always ready
    for (int i = 1; i <= 10; i++) step(1'b1, 8'(i + 8'h10), 32'(i), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: upstream holds each entry until accepted
    bp_data[0] = 32'h11; bp_data[1] = 32'h22; bp_data[2] = 32'h33;
    idx = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step(idx < 3, 8'(8'hA0 + idx), (idx < 3) ? bp_data[idx] : 32'h0, cyc >= 4, 1'b0);
      if (cyc == 1) begin
        chk("bp_count_after_two", 64'(count_o), 64'(DEPTH));
        chk("bp_in_ready_stalled", 64'(in_ready_o), 64'd0);
      end
      if (last_acc) idx++;
    end
    chk("bp_all_accepted", 64'(idx), 64'd3);

    // Flush with a concurrent valid input 0x44 while the stage is full
    step(1'b1, 8'h5A, 32'h55, 1'b0, 1'b0);
    step(1'b1, 8'h5B, 32'h66, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(count_o), 64'(DEPTH));
    step(1'b1, 8'h44, 32'h44, 1'b1, 1'b1);
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_ctrl",  64'(out_ctrl_o),  64'd0);
    chk("flush_data",  64'(out_data_o),  64'd0);
    chk("flush_count", 64'(count_o),     64'd0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with a valid entry held
    step(1'b1, 8'h77, 32'h77, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(out_valid_o), 64'd1);
    #1 rst_i = 1'b0;
    #1;
    chk("async_rst_valid",    64'(out_valid_o), 64'd0);
    chk("async_rst_ctrl",     64'(out_ctrl_o),  64'd0);
    chk("async_rst_data",     64'(out_data_o),  64'd0);
    chk("async_rst_count",    64'(count_o),     64'd0);
    chk("async_rst_in_ready", 64'(in_ready_o),  64'd1);
    @(posedge clk);
    #1 rst_i = 1'b1;
    step(1'b1, 8'h88, 32'h88, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));

    // Drain
    repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
